// File: rtl/usb_rx_unstuff_if.sv
// usb_rx_unstuff_if: serial bit input and UTMI-style byte output of the unstuffer
interface usb_rx_unstuff_if;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_eop;
  logic       rx_error;
  modport master (
    output bit_in, bit_valid,
    input  rx_data, rx_valid, rx_active, rx_eop, rx_error
  );
  modport slave (
    input  bit_in, bit_valid,
    output rx_data, rx_valid, rx_active, rx_eop, rx_error
  );
endinterface

// File: rtl/usb_rx_unstuff.sv
// usb_rx_unstuff: NRZI decode, SYNC hunt, bit unstuffing, HS EOP detection and byte assembly
module usb_rx_unstuff #(
  parameter int MIN_SYNC_ZEROS = 4,
  parameter int STUFF_LEN      = 6,
  parameter int IDLE_TIMEOUT   = 16
) (
  input logic clock,
  input logic reset,
  usb_rx_unstuff_if.slave rx
);
  localparam logic [3:0] MZ     = 4'(MIN_SYNC_ZEROS);
  localparam logic [3:0] SL     = 4'(STUFF_LEN);
  localparam logic [2:0] BC_EOP = 3'(STUFF_LEN + 1);
  localparam logic [7:0] IT     = 8'(IDLE_TIMEOUT - 1);
  typedef enum logic {HUNT, DATA} state_t;
  state_t     state;
  logic       prev_level;
  logic [3:0] zero_cnt;
  logic [3:0] ones_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] idle_cnt;
  logic [7:0] sr;
  logic       dec;
  logic [7:0] sh;
  assign dec = ~(rx.bit_in ^ prev_level);
  assign sh  = {dec, sr[7:1]};
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state        <= HUNT;
      prev_level   <= 1'b1;
      zero_cnt     <= '0;
      ones_cnt     <= '0;
      bit_cnt      <= '0;
      idle_cnt     <= '0;
      sr           <= '0;
      rx.rx_data   <= '0;
      rx.rx_valid  <= 1'b0;
      rx.rx_active <= 1'b0;
      rx.rx_eop    <= 1'b0;
      rx.rx_error  <= 1'b0;
    end else begin
      rx.rx_valid <= 1'b0;
      rx.rx_eop   <= 1'b0;
      rx.rx_error <= 1'b0;
      if (rx.bit_valid) prev_level <= rx.bit_in;
      if (state == HUNT) begin
        if (rx.bit_valid) begin
          if (!dec) zero_cnt <= (zero_cnt == 4'hf) ? zero_cnt : zero_cnt + 4'd1;
          else if (zero_cnt >= MZ) begin
            state        <= DATA;
            rx.rx_active <= 1'b1;
            zero_cnt     <= '0;
            ones_cnt     <= '0;
            bit_cnt      <= '0;
            idle_cnt     <= '0;
            sr           <= '0;
          end else zero_cnt <= '0;
        end
      end else if (rx.bit_valid) begin
        idle_cnt <= '0;
        // a 1 where a stuffed 0 was due is the HS EOP; a clean EOP leaves no partial data bits
        if (ones_cnt == SL && dec) begin
          state        <= HUNT;
          zero_cnt     <= '0;
          rx.rx_active <= 1'b0;
          rx.rx_eop    <= 1'b1;
          rx.rx_error  <= !(bit_cnt == 3'd0 || bit_cnt == BC_EOP);
        end else if (ones_cnt == SL) ones_cnt <= '0;
        else begin
          sr       <= sh;
          bit_cnt  <= bit_cnt + 3'd1;
          ones_cnt <= dec ? ones_cnt + 4'd1 : 4'd0;
          if (bit_cnt == 3'd7) begin
            rx.rx_data  <= sh;
            rx.rx_valid <= 1'b1;
          end
        end
      end else if (idle_cnt == IT) begin
        state        <= HUNT;
        zero_cnt     <= '0;
        rx.rx_active <= 1'b0;
        rx.rx_error  <= 1'b1;
      end else idle_cnt <= idle_cnt + 8'd1;
    end
endmodule

// File: tb/tb_usb_rx_unstuff.sv
// tb_usb_rx_unstuff: directed vectors for NRZI/SYNC/unstuff/EOP/timeout/reset
module tb_usb_rx_unstuff;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic level = 1'b1;
  int checks = 0;
  int errors = 0;
  int nval = 0, neop = 0, nerr = 0, nboth = 0;
  int v0, e0, r0, b0;
  logic [7:0] dv [64];
  logic act_end = 1'b0;
  usb_rx_unstuff_if bus();
  usb_rx_unstuff dut (.clock(clock), .reset(reset), .rx(bus));
  always #5 clock = ~clock;
  always @(negedge clock) begin
    if (bus.rx_valid) begin
      dv[nval & 63] <= bus.rx_data;
      nval <= nval + 1;
    end
    if (bus.rx_eop) neop <= neop + 1;
    if (bus.rx_error) nerr <= nerr + 1;
    if (bus.rx_eop && bus.rx_error) nboth <= nboth + 1;
    if (bus.rx_eop || bus.rx_error) act_end <= bus.rx_active;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic mark();
    v0 = nval; e0 = neop; r0 = nerr; b0 = nboth;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.bit_valid = 1'b0;
    bus.bit_in = 1'b1;
    level = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask
  task automatic send_line(input logic l);
    bus.bit_in = l;
    bus.bit_valid = 1'b1;
    @(posedge clock);
    #1 level = l;
  endtask
  task automatic send_dec(input logic d);
    send_line(d ? level : ~level);
  endtask
  task automatic sync();
    repeat (6) send_dec(1'b0);
    send_dec(1'b1);
  endtask
  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_dec(b[i]);
  endtask
  task automatic send_eop();
    send_line(~level);
    repeat (7) send_line(level);
  endtask
  task automatic idle(input int n);
    bus.bit_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end
  initial begin
    logic [6:0] jk;
    logic [3:0] pre;
    bus.bit_in = 1'b1;
    bus.bit_valid = 1'b0;
    #1;
    check("reset_out", {bus.rx_data, bus.rx_valid, bus.rx_active, bus.rx_eop, bus.rx_error}, 32'h0);
    do_reset();
    // line J,K,J,K,J,K,K then 0xA5 then a transition into 8 constant line bits
    mark();
    jk = 7'b1010100;
    for (int i = 6; i >= 0; i--) send_line(jk[i]);
    check("t1_active", bus.rx_active, 1);
    send_byte(8'hA5);
    check("t1_valid", bus.rx_valid, 1);
    check("t1_data", bus.rx_data, 8'hA5);
    send_eop();
    check("t1_eop", bus.rx_eop, 1);
    check("t1_err", bus.rx_error, 0);
    check("t1_act_low", bus.rx_active, 0);
    idle(3);
    check("t1_nval", nval - v0, 1);
    check("t1_data_hold", bus.rx_data, 8'hA5);
    // 0xFF with a stuffed 0 after the sixth 1, then 0x01
    do_reset();
    mark();
    sync();
    repeat (6) send_dec(1'b1);
    send_dec(1'b0);
    repeat (2) send_dec(1'b1);
    check("t2_valid_ff", bus.rx_valid, 1);
    check("t2_data_ff", bus.rx_data, 8'hFF);
    send_byte(8'h01);
    send_eop();
    idle(3);
    check("t2_nval", nval - v0, 2);
    check("t2_byte1", dv[(v0 + 1) & 63], 8'h01);
    check("t2_neop", neop - e0, 1);
    check("t2_nerr", nerr - r0, 0);
    // only 3 decoded zeros before the SYNC 1
    do_reset();
    mark();
    pre = 4'b1000;
    for (int i = 0; i < 4; i++) send_dec(pre[i]);
    send_byte(8'hA5);
    idle(3);
    check("t3_active", bus.rx_active, 0);
    check("t3_nval", nval - v0, 0);
    check("t3_nend", (neop - e0) + (nerr - r0), 0);
    // 4 data bits then 7 ones: byte 0xF2 completes, EOP lands with 2 partial bits
    do_reset();
    mark();
    sync();
    pre = 4'b0010;
    for (int i = 0; i < 4; i++) send_dec(pre[i]);
    repeat (7) send_dec(1'b1);
    check("t4_eop", bus.rx_eop, 1);
    check("t4_err", bus.rx_error, 1);
    idle(3);
    check("t4_nval", nval - v0, 1);
    check("t4_data", dv[v0 & 63], 8'hF2);
    check("t4_both", nboth - b0, 1);
    check("t4_act_end", act_end, 0);
    // SYNC then 7 ones: violation with 6 partial bits, no byte
    do_reset();
    mark();
    sync();
    repeat (7) send_dec(1'b1);
    idle(3);
    check("t4b_nval", nval - v0, 0);
    check("t4b_both", nboth - b0, 1);
    // 0x3C then bit_valid low for 16 cycles
    do_reset();
    mark();
    sync();
    send_byte(8'h3C);
    check("t5_valid", bus.rx_valid, 1);
    check("t5_data", bus.rx_data, 8'h3C);
    idle(15);
    check("t5_act_15", bus.rx_active, 1);
    check("t5_err_15", bus.rx_error, 0);
    idle(1);
    check("t5_err_16", bus.rx_error, 1);
    check("t5_eop_16", bus.rx_eop, 0);
    check("t5_act_16", bus.rx_active, 0);
    // asynchronous reset mid-byte, then a fresh packet
    do_reset();
    sync();
    send_byte(8'hC3);
    pre = 4'b0101;
    for (int i = 0; i < 4; i++) send_dec(pre[i]);
    send_dec(1'b1);
    check("t6_pre_active", bus.rx_active, 1);
    check("t6_pre_data", bus.rx_data, 8'hC3);
    #3 reset = 1'b1;
    #1;
    check("t6_async", {bus.rx_data, bus.rx_valid, bus.rx_active, bus.rx_eop, bus.rx_error}, 32'h0);
    bus.bit_valid = 1'b0;
    bus.bit_in = 1'b1;
    level = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    sync();
    send_byte(8'h5A);
    check("t6_valid", bus.rx_valid, 1);
    check("t6_data", bus.rx_data, 8'h5A);
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
